regfile: RTL and testbench
==========================

# regfile

General-purpose register file for the five-stage pipeline. It is the responder for the two register-read request ports driven by the decode stage and the sink for the write-back stage's write port. It provides combinational read data with same-cycle write-to-read bypass, keeps `$0` hard-wired to zero, and adds a registered debug read port for bench and monitor access.

## Interface

Parameters:
- `DATA_W`, 32: register width.
- `ADDR_W`, 5: register address width; depth is 2^ADDR_W = 32.

Ports (clock and reset first):
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high (`RstEnable` = 1).
- `we`  in  1  write enable from write-back.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `re1`  in  1  read enable, port 1; driven by decode `reg1_read_o`.
- `raddr1`  in  ADDR_W  read address, port 1; driven by decode `reg1_addr_o`.
- `rdata1`  out  DATA_W  read data, port 1; feeds decode `reg1_data_i`.
- `re2`  in  1  read enable, port 2; driven by decode `reg2_read_o`.
- `raddr2`  in  ADDR_W  read address, port 2; driven by decode `reg2_addr_o`.
- `rdata2`  out  DATA_W  read data, port 2; feeds decode `reg2_data_i`.
- `dbg_req`  in  1  debug read request, sampled on the clock edge.
- `dbg_addr`  in  ADDR_W  debug read address.
- `dbg_ack`  out  1  debug data valid, one-cycle pulse per request.
- `dbg_data`  out  DATA_W  debug read data; holds its value between acks.

## Operation

- Storage: 32 × DATA_W registers, `regs[0]`..`regs[31]`. `regs[0]` is never written and always reads as 0.
- Write: on an edge with `rst`=0, `we`=1 and `waddr`≠0, `regs[waddr]` ← `wdata`. Writes to address 0 are dropped silently.
- Read port n (n = 1, 2), combinational. Rules in priority order:
  - `rst`=1 → 0.
  - `re_n`=0 → 0.
  - `raddr_n`=0 → 0.
  - `we`=1 and `waddr`=`raddr_n` → `wdata` (bypass).
  - Otherwise → `regs[raddr_n]`.
- The two read ports are independent. Both may target the same address, including the address currently being written; each port then returns `wdata`.
- Debug port: on an edge with `rst`=0 and `dbg_req`=1, `dbg_data` ← value computed by the read-port rules with re=1 and addr=`dbg_addr`, and `dbg_ack` ← 1. The value includes the bypass, so a same-cycle write to `dbg_addr` returns `wdata`.
- If `dbg_req`=0 on an edge, `dbg_ack` ← 0 and `dbg_data` holds.
- Holding `dbg_req` high issues one request per cycle. `dbg_ack` stays high, with a new value every cycle.
- Reset: on an edge with `rst`=1, all 32 registers ← 0, `dbg_ack` ← 0, `dbg_data` ← 0. Any `we` or `dbg_req` in that cycle is ignored.

## Timing

- Read latency on ports 1 and 2: 0 cycles (combinational from address, enable and write inputs). No clock-to-read path other than through `regs`.
- Write latency: a write becomes visible through the array one cycle after its edge. It is visible in the same cycle through the bypass.
- Debug latency: 1 cycle from the request edge to `dbg_ack`/`dbg_data`.
- Reset outputs:
  - `rdata1` = `rdata2` = 0 while `rst`=1.
  - After the reset edge: `dbg_ack`=0, `dbg_data`=0, every register reads 0.
- Reset mid-operation: a write or debug request in the `rst` cycle is lost. The first accepted write is on the first edge with `rst`=0.
- Simultaneous events:
  - A write and reads of the same address in one cycle: the reads return `wdata`.
  - A write to address 0 plus a read of address 0: the read returns 0 (the address-0 rule takes priority over the bypass).
  - A write plus a debug request to the same address: `dbg_data` = `wdata`.
- Address wrap: not applicable. All 2^ADDR_W addresses are valid, with no out-of-range behaviour.

## Test plan

1. Reset, then read all 32 addresses on both ports with re=1 → every read returns 0x00000000. After the reset edge, `dbg_ack`=0 and `dbg_data`=0.
2. Write 0x0000FFFF to r3. Next cycle, read r3 on port 1 and r3 on port 2 → both return 0x0000FFFF. With `re1`=0, port 1 returns 0.
3. Bypass: in one cycle, `we`=1, `waddr`=5, `wdata`=0x12345678, `raddr1`=5, `raddr2`=5 → both ports return 0x12345678 in that same cycle. The following cycle, r5 reads 0x12345678 from the array.
4. Write 0xDEADBEEF to r0, then read r0 in that cycle and the next → 0 both times. The bypass must not fire.
5. Debug:
   - Write 0xA5A5A5A5 to r31.
   - Assert `dbg_req` for 3 consecutive cycles at addresses 31, 0, 31 → `dbg_ack` is high for 3 cycles, starting one cycle later, with data 0xA5A5A5A5, 0, 0xA5A5A5A5.
   - Deassert `dbg_req` → `dbg_ack`=0 and `dbg_data` holds 0xA5A5A5A5.
6. Reset mid-operation: write 0x11111111 to r7, then assert `rst` in the same cycle as a write of 0x22222222 to r7 → after reset, r7 reads 0. The first write accepted after `rst` falls is stored correctly.

Source files
------------

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports with
// write bypass, $0 hard-wired to zero, and a registered debug read port.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_dbg_data;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_rdd;

  // Address 0 outranks the bypass so a write to $0 never leaks through.
  function automatic logic [DATA_W-1:0] f_read(
    input logic              en,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (rst || !en || a == '0)
      v = '0;
    else if (we && waddr == a)
      v = wdata;
    else
      v = r_regs[a];
    return v;
  endfunction

  always_comb begin
    w_rd1 = f_read(re1, raddr1);
    w_rd2 = f_read(re2, raddr2);
    w_rdd = f_read(1'b1, dbg_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (we && waddr != '0) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_ack  <= 1'b0;
      r_dbg_data <= '0;
    end else if (dbg_req) begin
      r_dbg_ack  <= 1'b1;
      r_dbg_data <= w_rdd;
    end else begin
      r_dbg_ack  <= 1'b0;
    end
  end

  assign rdata1   = w_rd1;
  assign rdata2   = w_rd2;
  assign dbg_ack  = r_dbg_ack;
  assign dbg_data = r_dbg_data;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, writes, bypass, $0,
// debug port and reset during operation.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_ack  (dbg_ack),
    .dbg_data (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd9;
    dbg_req = 1'b0; dbg_addr = '0;
    #1;
    chk("rst_rd1", rdata1, 32'h0);
    chk("rst_rd2", rdata2, 32'h0);
    tick();
    chk("rst_ack", {31'b0, dbg_ack}, 32'h0);
    chk("rst_dbgd", dbg_data, 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      #1;
      chk("clr_rd1", rdata1, 32'h0);
      chk("clr_rd2", rdata2, 32'h0);
    end

    // write r3 then read it back
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000FFFF;
    tick();
    we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    chk("r3_rd1", rdata1, 32'h0000FFFF);
    chk("r3_rd2", rdata2, 32'h0000FFFF);
    re1 = 1'b0;
    #1;
    chk("r3_re1_off", rdata1, 32'h0);
    chk("r3_rd2_on", rdata2, 32'h0000FFFF);
    re1 = 1'b1;

    // same-cycle bypass on r5
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    chk("byp_rd1", rdata1, 32'h12345678);
    chk("byp_rd2", rdata2, 32'h12345678);
    tick();
    we = 1'b0;
    #1;
    chk("r5_arr1", rdata1, 32'h12345678);
    chk("r5_arr2", rdata2, 32'h12345678);
    raddr2 = 5'd3;
    #1;
    chk("indep_rd1", rdata1, 32'h12345678);
    chk("indep_rd2", rdata2, 32'h0000FFFF);

    // writes to $0 are dropped, bypass must not fire
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    chk("r0_byp1", rdata1, 32'h0);
    chk("r0_byp2", rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("r0_arr1", rdata1, 32'h0);
    chk("r0_arr2", rdata2, 32'h0);

    // debug port
    we = 1'b1; waddr = 5'd31; wdata = 32'hA5A5A5A5;
    tick();
    we = 1'b0;
    dbg_req = 1'b1; dbg_addr = 5'd31;
    #1;
    chk("dbg_pre_ack", {31'b0, dbg_ack}, 32'h0);
    tick();
    chk("dbg1_ack", {31'b0, dbg_ack}, 32'h1);
    chk("dbg1_data", dbg_data, 32'hA5A5A5A5);
    dbg_addr = 5'd0;
    tick();
    chk("dbg2_ack", {31'b0, dbg_ack}, 32'h1);
    chk("dbg2_data", dbg_data, 32'h0);
    dbg_addr = 5'd31;
    tick();
    chk("dbg3_ack", {31'b0, dbg_ack}, 32'h1);
    chk("dbg3_data", dbg_data, 32'hA5A5A5A5);
    dbg_req = 1'b0;
    tick();
    chk("dbg_idle_ack", {31'b0, dbg_ack}, 32'h0);
    chk("dbg_hold", dbg_data, 32'hA5A5A5A5);
    tick();
    chk("dbg_hold2", dbg_data, 32'hA5A5A5A5);

    // debug read sees the same-cycle write
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D;
    dbg_req = 1'b1; dbg_addr = 5'd9;
    tick();
    we = 1'b0; dbg_req = 1'b0;
    chk("dbg_byp_ack", {31'b0, dbg_ack}, 32'h1);
    chk("dbg_byp_data", dbg_data, 32'hCAFEF00D);

    // reset mid-operation
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    tick();
    we = 1'b0; raddr1 = 5'd7;
    #1;
    chk("r7_pre", rdata1, 32'h11111111);
    rst = 1'b1; we = 1'b1; wdata = 32'h22222222;
    dbg_req = 1'b1; dbg_addr = 5'd7;
    #1;
    chk("rst_hold_rd1", rdata1, 32'h0);
    tick();
    rst = 1'b0; we = 1'b0; dbg_req = 1'b0;
    raddr2 = 5'd31;
    #1;
    chk("r7_post", rdata1, 32'h0);
    chk("r31_post", rdata2, 32'h0);
    chk("post_ack", {31'b0, dbg_ack}, 32'h0);
    chk("post_dbgd", dbg_data, 32'h0);
    we = 1'b1; wdata = 32'h33333333;
    tick();
    we = 1'b0;
    #1;
    chk("r7_new", rdata1, 32'h33333333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
